// File: rtl/ks_pkg.sv
// Shared types, cell functions and pipeline-geometry helpers for the
// pipelined Kogge-Stone adder/subtractor.
package ks_pkg;

  // Operation select carried on in_sub.
  typedef enum logic {
    KS_ADD = 1'b0,
    KS_SUB = 1'b1
  } ks_op_e;

  // Number of prefix levels for a power-of-2 operand width.
  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

  // Accept-to-out_valid latency: input register, internal prefix registers,
  // output register.
  function automatic int ks_lat(input int levels, input int reg_every);
    return 2 + ((reg_every == 0) ? 0 : (levels - 1) / reg_every);
  endfunction

  // Default-configuration latency (WIDTH=32, REG_EVERY=2).
  localparam int KS_DEF_LAT = ks_lat(ks_levels(32), 2);

  // True when a pipeline register follows prefix level k.  The last level
  // never gets one because the output register follows it directly.
  function automatic bit ks_reg_after(input int k, input int levels,
                                      input int reg_every);
    return (reg_every != 0) && (((k + 1) % reg_every) == 0) && (k != levels - 1);
  endfunction

  // Pipeline stage index of the register that follows prefix level k.
  function automatic int ks_stage_of(input int k, input int reg_every);
    return (reg_every == 0) ? 0 : (k + 1) / reg_every;
  endfunction

  // Black cell: combine a high group with a lower, still incomplete group.
  function automatic logic [1:0] ks_black(input logic g_hi, input logic p_hi,
                                          input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  // Gray cell: the lower group already reaches carry-in, so only G matters.
  function automatic logic ks_gray(input logic g_hi, input logic p_hi,
                                   input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level of span SPAN.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  // Bits below SPAN pass through; bits whose partner is already complete use
  // a gray cell, the rest a black cell.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    g_out = g_in;
    p_out = p_in;
    for (int i = SPAN; i < WIDTH; i++) begin
      if (i < 2 * SPAN) begin
        g_out[i] = ks_gray(g_in[i], p_in[i], g_in[i-SPAN]);
      end else begin
        {g_out[i], p_out[i]} = ks_black(g_in[i], p_in[i], g_in[i-SPAN], p_in[i-SPAN]);
      end
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream on both
// sides.  Every pipeline stage is one slot of an elastic valid chain.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = ks_levels(WIDTH);
  localparam int LAT    = ks_lat(LEVELS, REG_EVERY);

  // Payload flowing through the prefix tree: group G/P, the original
  // propagate bits for the sum, carry-in for bit 0, and the sideband tag.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] po;
    logic             c0;
    logic [TAG_W-1:0] tag;
  } lvl_t;

  logic [LAT-1:0] v;     // stage occupied
  logic [LAT-1:0] take;  // stage may load this cycle

  // Stage s may load when empty or when its contents move on; the chain is
  // resolved from the output back so a full pipe still moves at 1 op/clk.
  always_comb begin
    take[LAT-1] = !v[LAT-1] || out_ready;
    for (int s = LAT - 2; s >= 0; s--) begin
      take[s] = !v[s] || take[s+1];
    end
  end

  assign in_ready  = !rst && take[0];
  assign out_valid = v[LAT-1];

  // Valid chain: each stage inherits the occupancy of the stage before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      // NOTE: sequential state uses <= so every stage sees pre-edge values.
      if (take[0]) v[0] <= in_valid;
      for (int s = 1; s < LAT; s++) begin
        if (take[s]) v[s] <= v[s-1];
      end
    end
  end

  // Operand conditioning: subtraction is A + ~B + !borrow.
  ks_op_e           op;
  logic [WIDTH-1:0] b_cond;
  assign op     = ks_op_e'(in_sub);
  assign b_cond = (op == KS_SUB) ? ~in_b : in_b;

  logic [WIDTH-1:0] a_q, b_q;
  logic             c0_q;
  logic [TAG_W-1:0] tag_q;

  // Input register (stage 0).
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; the valid chain alone decides
    // whether their contents mean anything.
    if (take[0] && in_valid) begin
      a_q   <= in_a;
      b_q   <= b_cond;
      c0_q  <= in_cin ^ in_sub;
      tag_q <= in_tag;
    end
  end

  lvl_t lvl0;

  // Bit-level p/g; carry-in is folded into bit 0 as the bit -1 generate.
  always_comb begin
    lvl0.p    = a_q ^ b_q;
    lvl0.po   = a_q ^ b_q;
    lvl0.g    = a_q & b_q;
    lvl0.g[0] = ks_gray(a_q[0] & b_q[0], a_q[0] ^ b_q[0], c0_q);
    lvl0.c0   = c0_q;
    lvl0.tag  = tag_q;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    lvl_t             d_in, d_nx, d_out;
    logic [WIDTH-1:0] nx_g, nx_p;

    if (k == 0) begin : g_first
      assign d_in = lvl0;
    end else begin : g_next
      assign d_in = g_lvl[k-1].d_out;
    end

    ks_prefix_level #(
      .WIDTH(WIDTH),
      .SPAN (1 << k)
    ) u_level (
      .g_in (d_in.g),
      .p_in (d_in.p),
      .g_out(nx_g),
      .p_out(nx_p)
    );

    assign d_nx = '{g: nx_g, p: nx_p, po: d_in.po, c0: d_in.c0, tag: d_in.tag};

    if (ks_reg_after(k, LEVELS, REG_EVERY)) begin : g_reg
      localparam int S = ks_stage_of(k, REG_EVERY);
      lvl_t q;
      // Internal prefix register, advancing with its valid-chain slot.
      always_ff @(posedge clk) begin
        if (take[S] && v[S-1]) q <= d_nx;
      end
      assign d_out = q;
    end else begin : g_comb
      assign d_out = d_nx;
    end
  end

  lvl_t             fin;
  logic [WIDTH-1:0] carry;
  assign fin   = g_lvl[LEVELS-1].d_out;
  assign carry = {fin.g[WIDTH-2:0], fin.c0};

  // Output register: sum, carry out and signed overflow; holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_tag  <= '0;
    end else if (take[LAT-1] && v[LAT-2]) begin
      out_sum  <= fin.po ^ carry;
      out_cout <= fin.g[WIDTH-1];
      out_ovf  <= fin.g[WIDTH-1] ^ fin.g[WIDTH-2];
      out_tag  <= fin.tag;
    end
  end

endmodule
